// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// One radix-2 step per clock: shift-add multiply, restoring divide, sign fix-up at the end.
module mult_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        mthi,
  input  logic        mtlo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  count;
  logic        accept;
  logic        last;
  logic        zero_div;
  logic        is_div;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic [31:0] mag_b;
  logic [31:0] step_hi;
  logic [31:0] step_lo;
  logic [32:0] sum;
  logic [32:0] diff;
  logic [63:0] prod_fix;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? -v : v;
  endfunction

  function automatic logic [31:0] cneg32(input logic [31:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [63:0] cneg64(input logic [63:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign last = (count == 5'd31);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    div_by_zero = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        busy = !zero_div;
        if (zero_div || last) state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        div_by_zero = zero_div;
        if (start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Multiply: acc_lo holds the multiplier and shifts right, product grows into acc_hi.
  // Divide: acc_lo holds the dividend shifting left into the partial remainder acc_hi.
  always_comb begin
    sum  = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? mag_b : 32'd0)};
    diff = {acc_hi, acc_lo[31]} - {1'b0, mag_b};
    if (is_div) begin
      if (!diff[32]) begin
        step_hi = diff[31:0];
        step_lo = {acc_lo[30:0], 1'b1};
      end else begin
        step_hi = {acc_hi[30:0], acc_lo[31]};
        step_lo = {acc_lo[30:0], 1'b0};
      end
    end else begin
      step_hi = sum[32:1];
      step_lo = {sum[0], acc_lo[31:1]};
    end
  end

  assign prod_fix = cneg64({step_hi, step_lo}, neg_q);

  // Operand magnitudes and result signs are frozen at acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_div <= op[1];
      acc_hi <= '0;
      acc_lo <= abs32(operand_a, ~op[0]);
      mag_b  <= abs32(operand_b, ~op[0]);
      neg_q  <= ~op[0] & (operand_a[31] ^ operand_b[31]);
      neg_r  <= ~op[0] & operand_a[31];
    end else if (state == CALC) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      zero_div <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      if (accept) begin
        count    <= '0;
        zero_div <= op[1] && (operand_b == 32'd0);
      end else if (state == CALC) begin
        count <= count + 5'd1;
      end

      // A start on the same edge wins over mthi/mtlo.
      if (state == CALC) begin
        if (last && !zero_div) begin
          if (is_div) begin
            hi <= cneg32(step_hi, neg_r);
            lo <= cneg32(step_lo, neg_q);
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
        end
      end else if (!accept) begin
        if (mthi) hi <= operand_a;
        if (mtlo) lo <= operand_a;
      end
    end
  end

endmodule
